// File: rtl/my_phase_demod_if.sv
// my_phase_demod_if: GPIO config/readback, ADC sample and timer phase bundle
// between the dither timer side (master) and the phase demodulator (slave).
interface my_phase_demod_if #(
  parameter int GPIO_WIDTH = 32,
  parameter int ADC_WIDTH  = 14
);
  logic [GPIO_WIDTH-1:0] GP_IN;
  logic [ADC_WIDTH-1:0]  ADC_IN;
  logic [1:0]            PHASE;
  logic [GPIO_WIDTH-1:0] GP_OUT;
  logic                  RES_VALID;
  logic                  CNT_MISMATCH;
  logic                  BUSY;

  modport master (
    output GP_IN, ADC_IN, PHASE,
    input  GP_OUT, RES_VALID, CNT_MISMATCH, BUSY
  );

  modport slave (
    input  GP_IN, ADC_IN, PHASE,
    output GP_OUT, RES_VALID, CNT_MISMATCH, BUSY
  );
endinterface

// File: rtl/my_phase_demod.sv
// my_phase_demod: samples the photodetector ADC in lock-step with the dither
// timer phase code, accumulates phase A and phase C samples, and after each
// full dither cycle publishes sum_A - sum_C on the GPIO readback word.
// Optional feature macro: MY_DEMOD_SAT_EN (saturating accumulators, overflow
// reported through CNT_MISMATCH). Undefined: accumulators wrap.
module my_phase_demod #(
  parameter int GPIO_WIDTH = 32,
  parameter int ADC_WIDTH  = 14,
  parameter int ACC_WIDTH  = 30,
  parameter int CNT_WIDTH  = 16
) (
  input logic ADC_CLK,
  input logic RST,
  my_phase_demod_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACC} state_t;
  typedef enum logic [1:0] {
    PH_STOP = 2'b00,
    PH_A    = 2'b01,
    PH_B    = 2'b10,
    PH_C    = 2'b11
  } phase_t;

  state_t                  state;
  logic [1:0]              phase_q;
  logic [15:0]             settle_cnt;
  logic [GPIO_WIDTH-1:0]   gp_out_q;
  logic                    res_valid_q;
  logic                    cnt_mm_q;

  logic [ACC_WIDTH-1:0]    sum_a, sum_c;
  logic [ACC_WIDTH-1:0]    sum_a_nxt, sum_c_nxt;
  logic [CNT_WIDTH-1:0]    cnt_a, cnt_c;
  logic                    a_seen, c_seen;
  logic [ACC_WIDTH-1:0]    adc_ext;
  logic [ACC_WIDTH:0]      diff;
  logic                    enabled, phase_chg, enter_a, do_clear, acc_step;
  logic                    unused_gp;
`ifdef MY_DEMOD_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0]      add_a_w, add_c_w;
  logic                    ovf_a, ovf_c, ovf_flag;
`endif

  // Only the enable bit and the settle count of the config word are used.
  assign unused_gp = ^bus.GP_IN[GPIO_WIDTH-2:16];

  // Control decode: an enabled return from IDLE counts as a phase change so a
  // re-enable while PHASE is unchanged still goes through SETTLE.
  always_comb begin
    enabled   = bus.GP_IN[GPIO_WIDTH-1] && (bus.PHASE != PH_STOP);
    phase_chg = enabled && ((bus.PHASE != phase_q) || (state == IDLE));
    enter_a   = phase_chg && (bus.PHASE == PH_A);
    do_clear  = !enabled || enter_a;
    acc_step  = enabled && !phase_chg &&
                ((state == ACC) || ((state == SETTLE) && (settle_cnt == '0)));
    adc_ext   = ACC_WIDTH'($signed(bus.ADC_IN));
    diff      = {sum_a[ACC_WIDTH-1], sum_a} - {sum_c[ACC_WIDTH-1], sum_c};
  end

  // Next accumulator values (wrapping or saturating add of the sample).
  always_comb begin
`ifdef MY_DEMOD_SAT_EN
    add_a_w   = {sum_a[ACC_WIDTH-1], sum_a} + {adc_ext[ACC_WIDTH-1], adc_ext};
    add_c_w   = {sum_c[ACC_WIDTH-1], sum_c} + {adc_ext[ACC_WIDTH-1], adc_ext};
    ovf_a     = add_a_w[ACC_WIDTH] ^ add_a_w[ACC_WIDTH-1];
    ovf_c     = add_c_w[ACC_WIDTH] ^ add_c_w[ACC_WIDTH-1];
    sum_a_nxt = add_a_w[ACC_WIDTH-1:0];
    sum_c_nxt = add_c_w[ACC_WIDTH-1:0];
    if (ovf_a) sum_a_nxt = add_a_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    if (ovf_c) sum_c_nxt = add_c_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
`else
    sum_a_nxt = sum_a + adc_ext;
    sum_c_nxt = sum_c + adc_ext;
`endif
  end

  // Per-phase accumulators, saturating sample counters and seen flags.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST || do_clear) begin
      sum_a    <= '0;
      sum_c    <= '0;
      cnt_a    <= '0;
      cnt_c    <= '0;
      a_seen   <= 1'b0;
      c_seen   <= 1'b0;
`ifdef MY_DEMOD_SAT_EN
      ovf_flag <= 1'b0;
`endif
    end else if (acc_step) begin
      if (bus.PHASE == PH_A) begin
        sum_a  <= sum_a_nxt;
        a_seen <= 1'b1;
        if (cnt_a != '1) cnt_a <= cnt_a + CNT_WIDTH'(1);
`ifdef MY_DEMOD_SAT_EN
        ovf_flag <= ovf_flag | ovf_a;
`endif
      end else if (bus.PHASE == PH_C) begin
        sum_c  <= sum_c_nxt;
        c_seen <= 1'b1;
        if (cnt_c != '1) cnt_c <= cnt_c + CNT_WIDTH'(1);
`ifdef MY_DEMOD_SAT_EN
        ovf_flag <= ovf_flag | ovf_c;
`endif
      end
    end
  end

  // Phase FSM with registered result outputs; latch happens on entry into A.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      phase_q     <= PH_STOP;
      settle_cnt  <= '0;
      gp_out_q    <= '0;
      res_valid_q <= 1'b0;
      cnt_mm_q    <= 1'b0;
    end else begin
      phase_q     <= bus.PHASE;
      res_valid_q <= 1'b0;
      if (!enabled) begin
        state <= IDLE;
      end else if (phase_chg) begin
        state      <= SETTLE;
        settle_cnt <= bus.GP_IN[15:0];
        if (enter_a && a_seen && c_seen) begin
          gp_out_q    <= GPIO_WIDTH'($signed(diff));
          res_valid_q <= 1'b1;
`ifdef MY_DEMOD_SAT_EN
          cnt_mm_q    <= (cnt_a != cnt_c) | ovf_flag;
`else
          cnt_mm_q    <= (cnt_a != cnt_c);
`endif
        end
      end else if (state == SETTLE) begin
        if (settle_cnt != '0) settle_cnt <= settle_cnt - 16'd1;
        else                  state      <= ACC;
      end
    end
  end

  assign bus.GP_OUT       = gp_out_q;
  assign bus.RES_VALID    = res_valid_q;
  assign bus.CNT_MISMATCH = cnt_mm_q;
  assign bus.BUSY         = (state != IDLE);

endmodule
